// File: rtl/mod5_pkg.sv
// Shared types and the modulo-5 residue step for the request scheduler.
// Pure declarations: no state, no timing.
package mod5_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

  typedef logic [2:0] rem_t;

  // One MSB-first step: rem' = (2*rem + bit) mod 5. The largest sum is 9,
  // so a single conditional subtract is enough.
  function automatic rem_t next_rem(input rem_t rem, input logic b);
    logic [3:0] t;
    t = {rem, 1'b0} + {3'b000, b};
    return (t >= 4'd5) ? rem_t'(t - 4'd5) : rem_t'(t);
  endfunction

endpackage

// File: rtl/mod5_serial_residue.sv
// Bit-serial modulo-5 residue engine; one bit per cycle while en is high.
// Latency 1 cycle per bit; no backpressure (clear has priority over en).
module mod5_serial_residue
  import mod5_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       en,
  input  logic       din,
  output logic [2:0] rem
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem <= '0;
    end else if (clear) begin
      rem <= '0;
    end else if (en) begin
      rem <= next_rem(rem, din);
    end
  end

endmodule

// File: rtl/mod5_req_scheduler.sv
// Round-robin scheduler sharing one serial mod-5 engine; rsp_valid at accept+WIDTH+1.
// Holds RESP while rsp_ready is low; MOD5_SCHED_REM_OUT_EN adds the rsp_rem port.
module mod5_req_scheduler
  import mod5_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 16,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_div5,
`ifdef MOD5_SCHED_REM_OUT_EN
  output logic [2:0]            rsp_rem,
`endif
  output logic                  busy
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    cnt_q;
  logic [IDW-1:0]   id_q, last_q;
  logic [IDW-1:0]   gnt_idx, cand;
  logic             gnt_any;
  logic             accept;
  logic [2:0]       rem;

  // Scan downwards so the final hit is the first valid index after last_q.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(last_q) + k) % NREQ);
      if (req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          req_ready[gnt_idx] = 1'b1;
          accept             = 1'b1;
          state_nxt          = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == '0) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shift_q <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      last_q  <= IDW'(NREQ - 1);
    end else if (accept) begin
      shift_q <= req_data[gnt_idx*WIDTH +: WIDTH];
      cnt_q   <= CW'(WIDTH - 1);
      id_q    <= gnt_idx;
      last_q  <= gnt_idx;
    end else if (state == SHIFT) begin
      shift_q <= shift_q << 1;
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  mod5_serial_residue u_residue (
    .clk    (clk),
    .resetn (resetn),
    .clear  (accept),
    .en     (state == SHIFT),
    .din    (shift_q[WIDTH-1]),
    .rem    (rem)
  );

  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_div5  = rsp_valid && (rem == 3'd0);
  assign rsp_id    = id_q;
`ifdef MOD5_SCHED_REM_OUT_EN
  assign rsp_rem   = rem;
`endif

endmodule
